// File: rtl/float16_div_if.sv
// Handshake bundle for the binary16 divider.
//   master: producer/consumer side (drives operands and out_ready).
//   slave : divider side (drives in_ready, out_valid and quotient).
//   in_valid/in_ready + floatA/floatB : operand channel
//   out_valid/out_ready + quotient    : result channel
interface float16_div_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] floatA;
    logic [15:0] floatB;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;

    modport master (
        output in_valid, floatA, floatB, out_ready,
        input  in_ready, out_valid, quotient
    );

    modport slave (
        input  in_valid, floatA, floatB, out_ready,
        output in_ready, out_valid, quotient
    );
endinterface

// File: rtl/float16_div_seq.sv
// Sequential IEEE-754 binary16 divider: quotient = floatA / floatB.
// Restoring radix-2 significand division, one quotient bit per cycle, truncating result,
// subnormal inputs read as zero, underflow flushed to zero.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : float16_div_if slave (operand and result valid/ready channels)
module float16_div_seq #(
    parameter int unsigned DIV_ITER  = 12,
    parameter logic [15:0] NAN_VALUE = 16'h7E00
) (
    input logic           clk,
    input logic           rst_n,
    float16_div_if.slave  bus
);

    typedef enum logic [2:0] {StIdle, StSpecial, StDivide, StNorm, StDone} state_e;

    localparam logic [3:0] LastIter = 4'(DIV_ITER - 1);

    state_e             state_q, state_d;
    logic               sign_q, sign_d;
    logic signed [6:0]  exp_q, exp_d;
    logic [10:0]        mb_q, mb_d;
    logic [11:0]        rem_q, rem_d;
    logic [11:0]        quo_q, quo_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [15:0]        result_q, result_d;

    // Operand decode
    logic              a_sign, b_sign;
    logic [4:0]        a_exp, b_exp;
    logic [9:0]        a_frac, b_frac;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic              res_nan, res_inf, res_zero;
    logic signed [6:0] exp_diff;

    // Datapath temporaries
    logic [11:0]       rem_sub;
    logic signed [6:0] exp_norm;
    logic [9:0]        frac_norm;

    always_comb begin
        a_sign   = bus.floatA[15];
        b_sign   = bus.floatB[15];
        a_exp    = bus.floatA[14:10];
        b_exp    = bus.floatB[14:10];
        a_frac   = bus.floatA[9:0];
        b_frac   = bus.floatB[9:0];
        a_nan    = (a_exp == 5'h1F) && (a_frac != 10'h0);
        b_nan    = (b_exp == 5'h1F) && (b_frac != 10'h0);
        a_inf    = (a_exp == 5'h1F) && (a_frac == 10'h0);
        b_inf    = (b_exp == 5'h1F) && (b_frac == 10'h0);
        // Subnormals are treated as zero
        a_zero   = (a_exp == 5'h00);
        b_zero   = (b_exp == 5'h00);
        res_nan  = a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf);
        res_inf  = a_inf || b_zero;
        res_zero = a_zero || b_inf;
        exp_diff = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + 7'sd15;
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mb_d     = mb_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        rem_sub  = rem_q - {1'b0, mb_q};
        // q lies in [0.5,2): renormalise by at most one position
        exp_norm  = quo_q[11] ? exp_q : exp_q - 7'sd1;
        frac_norm = quo_q[11] ? quo_q[10:1] : quo_q[9:0];

        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    sign_d = a_sign ^ b_sign;
                    exp_d  = exp_diff;
                    mb_d   = {1'b1, b_frac};
                    rem_d  = {2'b01, a_frac};
                    quo_d  = '0;
                    cnt_d  = '0;
                    if (res_nan) begin
                        result_d = NAN_VALUE;
                        state_d  = StSpecial;
                    end else if (res_inf) begin
                        result_d = {a_sign ^ b_sign, 5'h1F, 10'h000};
                        state_d  = StSpecial;
                    end else if (res_zero) begin
                        result_d = {a_sign ^ b_sign, 15'h0000};
                        state_d  = StSpecial;
                    end else begin
                        state_d  = StDivide;
                    end
                end
            end
            StSpecial: state_d = StDone;
            StDivide: begin
                if (rem_q >= {1'b0, mb_q}) begin
                    quo_d = {quo_q[10:0], 1'b1};
                    rem_d = {rem_sub[10:0], 1'b0};
                end else begin
                    quo_d = {quo_q[10:0], 1'b0};
                    rem_d = {rem_q[10:0], 1'b0};
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LastIter) begin
                    state_d = StNorm;
                end
            end
            StNorm: begin
                if (exp_norm >= 7'sd31) begin
                    result_d = {sign_q, 5'h1F, 10'h000};
                end else if (exp_norm <= 7'sd0) begin
                    result_d = {sign_q, 15'h0000};
                end else begin
                    result_d = {sign_q, exp_norm[4:0], frac_norm};
                end
                state_d = StDone;
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mb_q     <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mb_q     <= mb_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.quotient  = result_q;

endmodule

// File: tb/tb_float16_div_seq.sv
module tb_float16_div_seq;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    float16_div_if bus ();

    float16_div_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Issue one operation, measure accept-to-out_valid latency (accept edge counts as 1),
    // check the result, then accept it. Called #1 after a clock edge.
    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] q_exp, input int lat_exp);
        int cycles;
        bus.in_valid = 1'b1;
        bus.floatA   = a;
        bus.floatB   = b;
        check({tag, ".in_ready"}, 16'(bus.in_ready), 16'h1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        cycles = 1;
        while (!bus.out_valid && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check({tag, ".latency"}, 16'(cycles), 16'(lat_exp));
        check({tag, ".quotient"}, bus.quotient, q_exp);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, ".idle_in_ready"}, 16'(bus.in_ready), 16'h1);
        check({tag, ".idle_out_valid"}, 16'(bus.out_valid), 16'h0);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.floatA    = 16'h0000;
        bus.floatB    = 16'h0000;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset.in_ready", 16'(bus.in_ready), 16'h1);
        check("reset.out_valid", 16'(bus.out_valid), 16'h0);
        check("reset.quotient", bus.quotient, 16'h0000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Normal path
        do_op("div_20_4", 16'h4D00, 16'h4400, 16'h4500, 14);
        do_op("div_m24_4", 16'hCE00, 16'h4400, 16'hC600, 14);
        do_op("div_1_3", 16'h3C00, 16'h4200, 16'h3555, 14);

        // Special path
        do_op("div_by_zero", 16'h4400, 16'h0000, 16'h7C00, 2);
        do_op("zero_by_zero", 16'h0000, 16'h0000, 16'h7E00, 2);
        do_op("by_inf", 16'h9D1F, 16'h7C00, 16'h8000, 2);

        // Exponent range limits
        do_op("overflow", 16'h7BFF, 16'h0400, 16'h7C00, 14);
        do_op("underflow", 16'h0400, 16'h7BFF, 16'h0000, 14);

        // Back-pressure: result held, new operands ignored
        bus.in_valid = 1'b1;
        bus.floatA   = 16'h4D00;
        bus.floatB   = 16'h4400;
        @(posedge clk);
        #1;
        bus.floatA = 16'h3C00;
        bus.floatB = 16'h4200;
        for (int i = 0; i < 13 && !bus.out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 5; i++) begin
            check("hold.out_valid", 16'(bus.out_valid), 16'h1);
            check("hold.quotient", bus.quotient, 16'h4500);
            check("hold.in_ready", 16'(bus.in_ready), 16'h0);
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("release.in_ready", 16'(bus.in_ready), 16'h1);
        check("release.out_valid", 16'(bus.out_valid), 16'h0);
        do_op("after_hold", 16'h3C00, 16'h4200, 16'h3555, 14);

        // Reset mid-division aborts the operation
        bus.in_valid = 1'b1;
        bus.floatA   = 16'hCE00;
        bus.floatB   = 16'h4400;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("abort.in_ready", 16'(bus.in_ready), 16'h1);
        check("abort.out_valid", 16'(bus.out_valid), 16'h0);
        check("abort.quotient", bus.quotient, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("abort.no_stale", 16'(bus.out_valid), 16'h0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_op("post_reset", 16'h4D00, 16'h4400, 16'h4500, 14);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
